// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared widths, FSM state and grant encodings for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;

    localparam logic [3:0] c_sel_all = 4'b1111;

    typedef enum logic [2:0] {
        ArbIdle  = 3'd0,
        ArbIbus  = 3'd1,
        ArbDbus  = 3'd2,
        ArbIdone = 3'd3,
        ArbDdone = 3'd4
    } arb_state_e;

    typedef enum logic {
        GrantInst = 1'b0,
        GrantData = 1'b1
    } grant_e;

    // With both ports requesting, the port that did not win last time goes next.
    function automatic grant_e pick_grant(input logic   inst_ce,
                                          input logic   data_ce,
                                          input grant_e last);
        if (inst_ce && data_ce) begin
            return (last == GrantData) ? GrantInst : GrantData;
        end
        return data_ce ? GrantData : GrantInst;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates fetch and load/store ports onto one req/ack memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AddrWidth = InstAddrBus,
    parameter int DataWidth = RegBus
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 inst_ce_i,
    input  logic [AddrWidth-1:0] inst_addr_i,
    output logic [DataWidth-1:0] inst_data_o,
    output logic                 inst_done_o,
    output logic                 inst_stallreq_o,

    input  logic                 data_ce_i,
    input  logic                 data_we_i,
    input  logic [3:0]           data_sel_i,
    input  logic [AddrWidth-1:0] data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_done_o,
    output logic                 data_stallreq_o,

    input  logic                 flush_i,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_sel_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    arb_state_e           state_q,      state_d;
    grant_e               last_grant_q, last_grant_d;
    logic                 discard_q,    discard_d;

    logic                 mem_req_q,    mem_req_d;
    logic                 mem_we_q,     mem_we_d;
    logic [3:0]           mem_sel_q,    mem_sel_d;
    logic [AddrWidth-1:0] mem_addr_q,   mem_addr_d;
    logic [DataWidth-1:0] mem_wdata_q,  mem_wdata_d;

    logic [DataWidth-1:0] inst_data_q,  inst_data_d;
    logic [DataWidth-1:0] data_rdata_q, data_rdata_d;
    logic                 inst_done_q,  inst_done_d;
    logic                 data_done_q,  data_done_d;

    grant_e               w_grant;
    logic                 w_discard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ArbIdle;
            last_grant_q <= GrantInst;
            discard_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_sel_q    <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            discard_q    <= discard_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        discard_d    = discard_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_sel_d    = mem_sel_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;
        w_grant      = pick_grant(inst_ce_i, data_ce_i, last_grant_q);
        w_discard    = discard_q | flush_i;

        unique case (state_q)
            ArbIdle: begin
                if (inst_ce_i || data_ce_i) begin
                    mem_req_d    = 1'b1;
                    last_grant_d = w_grant;
                    if (w_grant == GrantData) begin
                        state_d     = ArbDbus;
                        mem_we_d    = data_we_i;
                        mem_sel_d   = data_sel_i;
                        mem_addr_d  = data_addr_i;
                        mem_wdata_d = data_wdata_i;
                    end else begin
                        state_d     = ArbIbus;
                        mem_we_d    = 1'b0;
                        mem_sel_d   = c_sel_all;
                        mem_addr_d  = inst_addr_i;
                        mem_wdata_d = '0;
                    end
                end
            end

            // A flush cannot abort the issued request; it only suppresses the result.
            ArbIbus: begin
                discard_d = w_discard;
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    if (w_discard) begin
                        state_d = ArbIdle;
                    end else begin
                        state_d     = ArbIdone;
                        inst_data_d = mem_rdata_i;
                        inst_done_d = 1'b1;
                    end
                end
            end

            ArbDbus: begin
                if (mem_ack_i) begin
                    mem_req_d    = 1'b0;
                    state_d      = ArbDdone;
                    data_rdata_d = mem_rdata_i;
                    data_done_d  = 1'b1;
                end
            end

            ArbIdone, ArbDdone: begin
                state_d = ArbIdle;
            end

            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    assign inst_stallreq_o = ~rst & inst_ce_i & (state_q != ArbIdone);
    assign data_stallreq_o = ~rst & data_ce_i & (state_q != ArbDdone);

    assign inst_data_o  = inst_data_q;
    assign inst_done_o  = inst_done_q;
    assign data_rdata_o = data_rdata_q;
    assign data_done_o  = data_done_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_sel_o    = mem_sel_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed and randomized checks of mem_arbiter against a
//               transaction-level model with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_ce_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_data_o;
    logic        inst_done_o;
    logic        inst_stallreq_o;
    logic        data_ce_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_sel_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        data_done_o;
    logic        data_stallreq_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .inst_ce_i       (inst_ce_i),
        .inst_addr_i     (inst_addr_i),
        .inst_data_o     (inst_data_o),
        .inst_done_o     (inst_done_o),
        .inst_stallreq_o (inst_stallreq_o),
        .data_ce_i       (data_ce_i),
        .data_we_i       (data_we_i),
        .data_sel_i      (data_sel_i),
        .data_addr_i     (data_addr_i),
        .data_wdata_i    (data_wdata_i),
        .data_rdata_o    (data_rdata_o),
        .data_done_o     (data_done_o),
        .data_stallreq_o (data_stallreq_o),
        .flush_i         (flush_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_sel_o       (mem_sel_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i),
        .mem_ack_i       (mem_ack_i)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural memory; unwritten words read back a pattern derived from the address.
    logic [31:0] mem_m [logic [31:0]];

    // Transaction model: phase 0 = free, 1 = access outstanding, 2 = result presented.
    int          phase_m   = 0;
    int          port_m    = 0;   // 0 = fetch, 1 = data
    int          last_m    = 0;
    int          wait_cnt  = 0;
    int          lat       = 0;
    int          force_lat = -1;
    bit          discard_m = 1'b0;
    bit          force_ack = 1'b0;
    bit          inst_served = 1'b0;
    bit          data_served = 1'b0;
    logic        g_we;
    logic [3:0]  g_sel;
    logic [31:0] g_addr, g_wdata;
    logic [31:0] inst_last = '0;
    logic [31:0] data_last = '0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        phase_m   = 0;
        last_m    = 0;
        discard_m = 1'b0;
        inst_last = '0;
        data_last = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_req"},   32'(mem_req_o),       32'h0);
        chk({tag, "_mem_we"},    32'(mem_we_o),        32'h0);
        chk({tag, "_mem_sel"},   32'(mem_sel_o),       32'h0);
        chk({tag, "_mem_addr"},  mem_addr_o,           32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_o,          32'h0);
        chk({tag, "_inst_data"}, inst_data_o,          32'h0);
        chk({tag, "_data_rd"},   data_rdata_o,         32'h0);
        chk({tag, "_inst_done"}, 32'(inst_done_o),     32'h0);
        chk({tag, "_data_done"}, 32'(data_done_o),     32'h0);
        chk({tag, "_inst_stall"}, 32'(inst_stallreq_o), 32'(!rst && inst_ce_i));
        chk({tag, "_data_stall"}, 32'(data_stallreq_o), 32'(!rst && data_ce_i));
    endtask

    // One clock cycle: memory response, output checks, then model advance at the edge.
    task automatic step();
        logic [31:0] v;
        bit          inst_res, data_res;
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (phase_m == 1) begin
            if (wait_cnt >= lat) begin
                mem_ack_i = 1'b1;
                if (g_we) begin
                    v = rd(g_addr);
                    for (int b = 0; b < 4; b++)
                        if (g_sel[b]) v[8*b +: 8] = g_wdata[8*b +: 8];
                    mem_m[g_addr] = v;
                end else begin
                    mem_rdata_i = rd(g_addr);
                end
            end
        end else if (force_ack || $urandom_range(0, 5) == 0) begin
            mem_ack_i = 1'b1;
        end
        #1;
        inst_res = (phase_m == 2) && (port_m == 0);
        data_res = (phase_m == 2) && (port_m == 1);
        chk("inst_stallreq", 32'(inst_stallreq_o), 32'(!rst && inst_ce_i && !inst_res));
        chk("data_stallreq", 32'(data_stallreq_o), 32'(!rst && data_ce_i && !data_res));
        chk("inst_done",     32'(inst_done_o),     32'(inst_res));
        chk("data_done",     32'(data_done_o),     32'(data_res));
        chk("mem_req",       32'(mem_req_o),       32'(phase_m == 1));
        chk("inst_data",     inst_data_o,          inst_last);
        chk("data_rdata",    data_rdata_o,         data_last);
        if (phase_m == 1) begin
            chk("mem_addr", mem_addr_o,       g_addr);
            chk("mem_we",   32'(mem_we_o),    32'(g_we));
            chk("mem_sel",  32'(mem_sel_o),   32'(g_sel));
            if (port_m == 1) chk("mem_wdata", mem_wdata_o, g_wdata);
        end
        inst_served = inst_res;
        data_served = data_res;

        if (rst) begin
            reset_model();
        end else begin
            case (phase_m)
                0: if (inst_ce_i || data_ce_i) begin
                    if (inst_ce_i && data_ce_i) port_m = (last_m == 1) ? 0 : 1;
                    else                        port_m = data_ce_i ? 1 : 0;
                    last_m    = port_m;
                    phase_m   = 1;
                    wait_cnt  = 0;
                    discard_m = 1'b0;
                    lat       = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                    if (port_m == 1) begin
                        g_addr = data_addr_i; g_we = data_we_i;
                        g_sel  = data_sel_i;  g_wdata = data_wdata_i;
                    end else begin
                        g_addr = inst_addr_i; g_we = 1'b0;
                        g_sel  = 4'hF;        g_wdata = '0;
                    end
                end
                1: begin
                    if (port_m == 0 && flush_i) discard_m = 1'b1;
                    if (mem_ack_i) begin
                        if (port_m == 0 && discard_m) begin
                            phase_m = 0;
                        end else begin
                            phase_m = 2;
                            if (port_m == 0) inst_last = mem_rdata_i;
                            else             data_last = mem_rdata_i;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
                default: phase_m = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        check_all_zero("reset");
        rst = 1'b0;

        // Fetch with ack on the first request cycle
        mem_m[32'h100] = 32'h3C01_1234;
        force_lat   = 0;
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h100;
        repeat (3) step();
        inst_ce_i = 1'b0;
        chk("fetch_data", inst_data_o, 32'h3C01_1234);
        step();

        // Store with three wait cycles, then read it back
        force_lat    = 3;
        data_ce_i    = 1'b1;
        data_we_i    = 1'b1;
        data_sel_i   = 4'b0011;
        data_addr_i  = 32'h2000;
        data_wdata_i = 32'hAABB_CCDD;
        repeat (6) step();
        data_we_i = 1'b0;
        force_lat = 1;
        repeat (4) step();
        data_ce_i = 1'b0;
        chk("store_readback", data_rdata_o, 32'h2000_CCDD);
        step();

        // Simultaneous requests after reset alternate data / inst
        rst = 1'b1;
        step();
        rst = 1'b0;
        force_lat   = 0;
        inst_ce_i   = 1'b1; inst_addr_i = 32'h100;
        data_ce_i   = 1'b1; data_addr_i = 32'h300; data_we_i = 1'b0;
        repeat (20) step();
        inst_ce_i = 1'b0;
        data_ce_i = 1'b0;
        step();

        // Flush while the fetch waits: result is dropped
        force_lat   = 3;
        inst_ce_i   = 1'b1;
        inst_addr_i = 32'h140;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        repeat (3) step();
        inst_ce_i = 1'b0;
        step();
        chk("flush_keep", inst_data_o, 32'h3C01_1234);
        step();

        // Reset in the middle of a data access, followed by a late ack
        data_ce_i   = 1'b1;
        data_addr_i = 32'h300;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        data_ce_i = 1'b0;
        check_all_zero("midreset");
        force_ack = 1'b1;
        repeat (3) step();
        force_ack = 1'b0;
        step();

        // Randomized traffic
        force_lat = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!inst_ce_i || inst_served) begin
                inst_ce_i   = ($urandom_range(0, 2) != 0);
                inst_addr_i = 32'h100 + 32'(4 * $urandom_range(0, 15));
            end else if ($urandom_range(0, 40) == 0) begin
                inst_ce_i = 1'b0;
            end
            if (!data_ce_i || data_served) begin
                data_ce_i    = ($urandom_range(0, 2) != 0);
                data_we_i    = ($urandom_range(0, 1) != 0);
                data_sel_i   = 4'($urandom_range(1, 15));
                data_addr_i  = 32'h100 + 32'(4 * $urandom_range(0, 15));
                data_wdata_i = $urandom;
            end else if ($urandom_range(0, 40) == 0) begin
                data_ce_i = 1'b0;
            end
            flush_i = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
